// File: rtl/axi_stream_width_downsizer.sv
// axi_stream_width_downsizer: splits each IN_BYTES-wide AXI-Stream beat into OUT_BYTES-wide sub-beats, lowest lanes first, skipping null sub-beats
// Ports:
//   clk, reset            sole clock, synchronous active-high reset
//   s_axis_*              wide slave side (tvalid/tready/tdata/tstrb/tkeep/tlast/tid/tdest/tuser)
//   m_axis_*              narrow master side, driven only from the holding register
module axi_stream_width_downsizer #(
    parameter int IN_BYTES   = 4,
    parameter int OUT_BYTES  = 1,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [8*IN_BYTES-1:0]   s_axis_tdata,
    input  logic [IN_BYTES-1:0]     s_axis_tstrb,
    input  logic [IN_BYTES-1:0]     s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [8*OUT_BYTES-1:0]  m_axis_tdata,
    output logic [OUT_BYTES-1:0]    m_axis_tstrb,
    output logic [OUT_BYTES-1:0]    m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);
    localparam int RATIO = IN_BYTES / OUT_BYTES;
    localparam int IW    = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam int OW    = 8 * OUT_BYTES;

    if (IN_BYTES % OUT_BYTES != 0) begin : g_bad_ratio
        $error("IN_BYTES must be an integer multiple of OUT_BYTES");
    end

    logic [8*IN_BYTES-1:0] data_q;
    logic [IN_BYTES-1:0]   strb_q, keep_q;
    logic                  last_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [USER_WIDTH-1:0] user_q;
    logic                  full_q, full_d;
    logic [IW-1:0]         idx_q, idx_d, first_nz, next_nz;
    logic [RATIO-1:0]      nonnull;
    logic                  is_final, s_hs, m_hs;

    // Descending scan so the last hit is the lowest qualifying sub-beat
    always_comb begin
        nonnull  = '0;
        first_nz = '0;
        next_nz  = idx_q;
        is_final = 1'b1;
        for (int k = RATIO - 1; k >= 0; k--) begin
            nonnull[k] = |keep_q[k*OUT_BYTES +: OUT_BYTES];
            if (|s_axis_tkeep[k*OUT_BYTES +: OUT_BYTES]) first_nz = IW'(k);
            if (nonnull[k] && k > int'(idx_q)) begin
                is_final = 1'b0;
                next_nz  = IW'(k);
            end
        end
    end

    // A new beat may load in the same cycle the final sub-beat leaves
    assign s_axis_tready = !reset && (!full_q || (m_axis_tready && is_final));
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = full_q && m_axis_tready;
    assign full_d        = s_hs ? 1'b1 : (m_hs && is_final) ? 1'b0 : full_q;
    assign idx_d         = s_hs ? first_nz : (m_hs && !is_final) ? next_nz : idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            full_q <= full_d;
            idx_q  <= idx_d;
            if (s_hs) begin
                data_q <= s_axis_tdata;
                strb_q <= s_axis_tstrb;
                keep_q <= s_axis_tkeep;
                last_q <= s_axis_tlast;
                id_q   <= s_axis_tid;
                dest_q <= s_axis_tdest;
                user_q <= s_axis_tuser;
            end
        end
    end

    assign m_axis_tvalid = full_q;
    assign m_axis_tdata  = data_q[idx_q*OW +: OW];
    assign m_axis_tstrb  = strb_q[idx_q*OUT_BYTES +: OUT_BYTES];
    assign m_axis_tkeep  = keep_q[idx_q*OUT_BYTES +: OUT_BYTES];
    assign m_axis_tlast  = last_q && is_final;
    assign m_axis_tid    = id_q;
    assign m_axis_tdest  = dest_q;
    assign m_axis_tuser  = user_q;
endmodule
